// File: rtl/alu_request_arbiter_pkg.sv
// Shared constants for the ALU request arbiter: FSM encoding, response timeout
// limit and default datapath widths.
package alu_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_EXEC = 2'd1;
  localparam arb_state_t ST_RESP = 2'd2;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_SEL_W  = 3;
  localparam int LAT_CNT_W  = 4;

endpackage

// File: rtl/alu_request_arbiter_if.sv
// Requester-side request/response bundle of the ALU arbiter. Slices of the
// packed operand buses belong to requester i.
interface alu_request_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_W   = DEF_SEL_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*SEL_W-1:0]  req_sel;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_flag;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flag
  );

endinterface

// File: rtl/alu_request_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first set request at
// or above ptr, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any
);

  localparam int SUM_W = PTR_W + 1;

  logic [SUM_W-1:0] pos;
  logic [PTR_W-1:0] idx;
  logic             found;

  // ptr is always below NUM_REQ, so a single conditional subtract wraps it
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + SUM_W'(k);
      if (pos >= SUM_W'(NUM_REQ)) begin
        pos = pos - SUM_W'(NUM_REQ);
      end
      idx = pos[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one PrimitiveALU between NUM_REQ requesters.
// Optional response timeout with timeout_err pulse: define ARB_RSP_TIMEOUT_EN.
module alu_request_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_request_arbiter_if.slave bus,
  output logic                 alu_load,
  output logic [DATA_W-1:0]    alu_in_a,
  output logic [DATA_W-1:0]    alu_in_b,
  output logic [SEL_W-1:0]     alu_select,
  input  logic [DATA_W-1:0]    alu_out,
  input  logic                 alu_flag,
  output logic                 busy
`ifdef ARB_RSP_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [LAT_CNT_W-1:0] LAT_CNT = LAT_CNT_W'(ALU_LAT);

  arb_state_t           state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d, ptr_next;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_flag_q, rsp_flag_d;
  logic                 alu_load_q, alu_load_d;
  logic [DATA_W-1:0]    a_q, a_d, b_q, b_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [NUM_REQ-1:0]   pick_grant;
  logic                 pick_any;
  logic [DATA_W-1:0]    pick_a, pick_b;
  logic [SEL_W-1:0]     pick_sel;
  logic                 rsp_hs;
`ifdef ARB_RSP_TIMEOUT_EN
  logic [7:0]           to_cnt_q, to_cnt_d;
  logic                 timeout_err_q, timeout_err_d;
`endif

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  always_comb begin
    pick_a   = '0;
    pick_b   = '0;
    pick_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        pick_a   = bus.req_a[i*DATA_W +: DATA_W];
        pick_b   = bus.req_b[i*DATA_W +: DATA_W];
        pick_sel = bus.req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  // The requester just served drops to lowest priority next round
  always_comb begin
    ptr_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        ptr_next = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  assign rsp_hs = |(rsp_valid_q & bus.rsp_ready);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    req_ready_d = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flag_d  = rsp_flag_q;
    alu_load_d  = alu_load_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    lat_cnt_d   = lat_cnt_q;
`ifdef ARB_RSP_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d     = pick_grant;
          req_ready_d = pick_grant;
          a_d         = pick_a;
          b_d         = pick_b;
          sel_d       = pick_sel;
          alu_load_d  = 1'b1;
          lat_cnt_d   = '0;
          state_d     = ST_EXEC;
        end
      end
      // load is held ALU_LAT cycles; one more cycle lets the ALU output settle
      ST_EXEC: begin
        if (lat_cnt_q == LAT_CNT) begin
          rsp_data_d  = alu_out;
          rsp_flag_d  = alu_flag;
          rsp_valid_d = grant_q;
          alu_load_d  = 1'b0;
          lat_cnt_d   = '0;
          state_d     = ST_RESP;
`ifdef ARB_RSP_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end else begin
          lat_cnt_d  = lat_cnt_q + 1'b1;
          alu_load_d = (lat_cnt_q + 1'b1) < LAT_CNT;
        end
      end
      ST_RESP: begin
        if (rsp_hs) begin
          rsp_valid_d = '0;
          alu_load_d  = 1'b0;
          ptr_d       = ptr_next;
          state_d     = ST_IDLE;
        end
`ifdef ARB_RSP_TIMEOUT_EN
        else if (to_cnt_q == TIMEOUT_LIMIT - 8'd1) begin
          rsp_valid_d   = '0;
          alu_load_d    = 1'b0;
          ptr_d         = ptr_next;
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= 1'b0;
      alu_load_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      lat_cnt_q   <= '0;
`ifdef ARB_RSP_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flag_q  <= rsp_flag_d;
      alu_load_q  <= alu_load_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      lat_cnt_q   <= lat_cnt_d;
`ifdef ARB_RSP_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flag  = rsp_flag_q;
  assign alu_load      = alu_load_q;
  assign alu_in_a      = a_q;
  assign alu_in_b      = b_q;
  assign alu_select    = sel_q;
  assign busy          = (state_q != ST_IDLE);
`ifdef ARB_RSP_TIMEOUT_EN
  assign timeout_err   = timeout_err_q;
`endif

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Scoreboard bench for alu_request_arbiter with a registered reference ALU and
// simple hold-until-ready requester models.
module tb_alu_request_arbiter;
  import alu_arb_pkg::*;

  localparam int NR      = 4;
  localparam int DW      = 8;
  localparam int SW      = 3;
  localparam int ALU_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_load;
  logic [DW-1:0] alu_in_a, alu_in_b;
  logic [SW-1:0] alu_select;
  logic [DW-1:0] alu_out = '0;
  logic          alu_flag = 1'b0;
  logic          busy;
`ifdef ARB_RSP_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 clk = ~clk;

  alu_request_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .SEL_W(SW)) bus ();

  alu_request_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .SEL_W(SW), .ALU_LAT(ALU_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_load   (alu_load),
    .alu_in_a   (alu_in_a),
    .alu_in_b   (alu_in_b),
    .alu_select (alu_select),
    .alu_out    (alu_out),
    .alu_flag   (alu_flag),
    .busy       (busy)
`ifdef ARB_RSP_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic          flag;
  } exp_t;

  exp_t          exp_q[$];
  int            grant_log[$];
  exp_t          mon_e;
  logic [DW-1:0] op_a[NR];
  logic [DW-1:0] op_b[NR];
  logic [SW-1:0] op_sel[NR];
  int            left[NR];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            t_acc = 0;
  int            t_hs = 0;
  int            rdy_pulses = 0;
  int            load_cnt = 0;
  logic [DW-1:0] last_data = '0;
  logic          last_flag = 1'b0;

  // Reference ALU: add (flag=carry), sub (flag=borrow), and/or/xor (flag=zero)
  function automatic logic [DW:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [SW-1:0] sel);
    logic [DW:0] r;
    r = '0;
    case (sel)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {(a < b), a - b};
      3'd2:    r = {~|(a & b), a & b};
      3'd3:    r = {~|(a | b), a | b};
      3'd4:    r = {~|(a ^ b), a ^ b};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  // Registered ALU with one cycle of latency from load
  always @(posedge clk) begin
    if (alu_load) {alu_flag, alu_out} <= alu_ref(alu_in_a, alu_in_b, alu_select);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [SW-1:0] sel, input int count);
    op_a[idx]   = a;
    op_b[idx]   = b;
    op_sel[idx] = sel;
    left[idx]   = count;
  endtask

  task automatic syncInputs();
    @(posedge clk);
    #1;
  endtask

  function automatic bit anyLeft();
    for (int i = 0; i < NR; i++) if (left[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || bus.req_valid != '0 || exp_q.size() != 0 || anyLeft()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    checkOutput({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({pfx, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    checkOutput({pfx, "_rsp_flag"}, 32'(bus.rsp_flag), 32'd0);
    checkOutput({pfx, "_alu_load"}, 32'(alu_load), 32'd0);
    checkOutput({pfx, "_alu_in_a"}, 32'(alu_in_a), 32'd0);
    checkOutput({pfx, "_alu_in_b"}, 32'(alu_in_b), 32'd0);
    checkOutput({pfx, "_alu_select"}, 32'(alu_select), 32'd0);
    checkOutput({pfx, "_busy"}, 32'(busy), 32'd0);
`ifdef ARB_RSP_TIMEOUT_EN
    checkOutput({pfx, "_timeout_err"}, 32'(timeout_err), 32'd0);
`endif
  endtask

  task automatic applyReset();
    syncInputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    grant_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor/scoreboard plus requester models, all sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_ready != '0) begin
        checkOutput("grant_onehot", 32'($onehot(bus.req_ready)), 32'd1);
        for (int i = 0; i < NR; i++) begin
          if (bus.req_ready[i]) begin
            checkOutput("grant_to_valid", 32'(bus.req_valid[i]), 32'd1);
            mon_e.idx = i;
            {mon_e.flag, mon_e.data} = alu_ref(op_a[i], op_b[i], op_sel[i]);
            exp_q.push_back(mon_e);
            grant_log.push_back(i);
            t_acc = cyc;
            rdy_pulses++;
          end
        end
      end
      if (alu_load) load_cnt++;
      if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_rsp", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("rsp_valid_bit", 32'(bus.rsp_valid), 32'(1) << mon_e.idx);
          checkOutput("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
          checkOutput("rsp_flag", 32'(bus.rsp_flag), 32'(mon_e.flag));
          t_hs = cyc;
          last_data = bus.rsp_data;
          last_flag = bus.rsp_flag;
        end
      end
`ifdef ARB_RSP_TIMEOUT_EN
      if (timeout_err && exp_q.size() != 0) void'(exp_q.pop_front());
`endif
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready[i] && left[i] > 0) begin
          left[i]--;
          op_a[i]   = DW'($urandom);
          op_b[i]   = DW'($urandom);
          op_sel[i] = SW'($urandom_range(4, 0));
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]            = (left[i] > 0);
      bus.req_a[i*DW +: DW]       = op_a[i];
      bus.req_b[i*DW +: DW]       = op_b[i];
      bus.req_sel[i*SW +: SW]     = op_sel[i];
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, stable, extra, vcnt, b2b;
    logic [DW-1:0] held;

    for (int i = 0; i < NR; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_sel[i] = '0; left[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = '0;

    $display("[TB] reset and single request");
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 4'hF;
    syncInputs();
    rdy_pulses = 0;
    load_cnt   = 0;
    applyStimulus(0, 8'h12, 8'h05, 3'd0, 1);
    waitDone("t1_done", 50);
    checkOutput("t1_ready_pulses", 32'(rdy_pulses), 32'd1);
    checkOutput("t1_load_cycles", 32'(load_cnt), 32'(ALU_LAT));
    checkOutput("t1_data", 32'(last_data), 32'h17);
    checkOutput("t1_flag", 32'(last_flag), 32'd0);
    checkOutput("t1_turnaround", 32'(t_hs - t_acc + 2), 32'(ALU_LAT + 3));

    $display("[TB] all four requesters at once");
    applyReset();
    syncInputs();
    for (int i = 0; i < NR; i++) applyStimulus(i, DW'($urandom), DW'($urandom), SW'($urandom_range(4, 0)), 1);
    waitDone("t2_done", 100);
    checkOutput("t2_grants", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < grant_log.size(); k++) checkOutput("t2_order", 32'(grant_log[k]), 32'(k));

    $display("[TB] round-robin fairness");
    grant_log.delete();
    syncInputs();
    applyStimulus(0, DW'($urandom), DW'($urandom), 3'd1, 3);
    applyStimulus(2, DW'($urandom), DW'($urandom), 3'd4, 3);
    waitDone("t3_done", 100);
    checkOutput("t3_grants", 32'(grant_log.size()), 32'd6);
    b2b = 0;
    for (int k = 0; k < grant_log.size(); k++) begin
      checkOutput("t3_order", 32'(grant_log[k]), (k % 2 == 0) ? 32'd0 : 32'd2);
      if (k > 0 && grant_log[k] == 0 && grant_log[k-1] == 0) b2b++;
    end
    checkOutput("t3_no_repeat0", 32'(b2b), 32'd0);

    $display("[TB] response backpressure");
    grant_log.delete();
    bus.rsp_ready = 4'b0001;
    syncInputs();
    applyStimulus(1, DW'($urandom), DW'($urandom), 3'd0, 1);
    n = 0;
    while (!bus.rsp_valid[1] && n < 20) begin @(negedge clk); n++; end
    checkOutput("t4_rsp_seen", 32'(n < 20), 32'd1);
    held = bus.rsp_data;
    syncInputs();
    applyStimulus(0, DW'($urandom), DW'($urandom), 3'd2, 1);
    stable = 0;
    extra  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid == 4'b0010 && bus.rsp_data == held) stable++;
      if (bus.req_ready != '0) extra++;
    end
    checkOutput("t4_stable_cycles", 32'(stable), 32'd20);
    checkOutput("t4_no_new_grant", 32'(extra), 32'd0);
    bus.rsp_ready = 4'b0011;
    waitDone("t4_done", 50);
    checkOutput("t4_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      checkOutput("t4_first", 32'(grant_log[0]), 32'd1);
      checkOutput("t4_second", 32'(grant_log[1]), 32'd0);
    end

    $display("[TB] reset during EXEC");
    bus.rsp_ready = 4'hF;
    syncInputs();
    applyStimulus(1, DW'($urandom), DW'($urandom), 3'd3, 1);
    n = 0;
    while (!bus.req_ready[1] && n < 20) begin @(negedge clk); n++; end
    checkOutput("t5_granted", 32'(n < 20), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("t5_async");
    exp_q.delete();
    grant_log.delete();
    for (int i = 0; i < NR; i++) left[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0 || busy) vcnt++;
    end
    checkOutput("t5_quiet_after_reset", 32'(vcnt), 32'd0);
    syncInputs();
    applyStimulus(3, DW'($urandom), DW'($urandom), 3'd0, 1);
    waitDone("t5_done", 50);
    checkOutput("t5_grants", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() == 1) checkOutput("t5_first_req3", 32'(grant_log[0]), 32'd3);

`ifdef ARB_RSP_TIMEOUT_EN
    $display("[TB] response timeout");
    bus.rsp_ready = '0;
    syncInputs();
    applyStimulus(0, DW'($urandom), DW'($urandom), 3'd0, 1);
    n = 0;
    while (bus.rsp_valid == '0 && n < 20) begin @(negedge clk); n++; end
    checkOutput("t6_rsp_seen", 32'(n < 20), 32'd1);
    vcnt = 0;
    while (bus.rsp_valid != '0 && vcnt < 400) begin vcnt++; @(negedge clk); end
    checkOutput("t6_resp_cycles", 32'(vcnt), 32'd255);
    checkOutput("t6_timeout_pulse", 32'(timeout_err), 32'd1);
    checkOutput("t6_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    checkOutput("t6_idle", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t6_pulse_len", 32'(timeout_err), 32'd0);
    bus.rsp_ready = 4'hF;
    waitDone("t6_done", 20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
